// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/OR/XOR plus iterative MUL/DIVU/REMU
// (one bit per clock through a shared adder), with a start/busy/done handshake.
module alu_mc #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic [2:0]       ALUCtrl,
  output logic [width-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic             busy,
  output logic             done
);

  localparam int unsigned cnt_w = $clog2(width);
  localparam int unsigned add_w = width + 1;
  localparam int unsigned sum_w = width + 2;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(width - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_DIVU = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [cnt_w-1:0]   cnt;
  logic [2:0]         op_q;
  logic [width-1:0]   acc;   // product high half / partial remainder
  logic [width-1:0]   qr;    // multiplier bits / dividend-then-quotient
  logic [width-1:0]   breg;

  logic               is_iter;
  logic               is_sub;
  logic [add_w-1:0]   add_a;
  logic [add_w-1:0]   add_b;
  logic               cin;
  logic [sum_w-1:0]   sum;
  logic               div_ge;
  logic [width-1:0]   acc_n;
  logic [width-1:0]   qr_n;
  logic [width-1:0]   fin_res;
  logic               fin_v;
  logic               fin_c;
  logic [3:0]         fin_flags;

  // Shared adder: ADD/SUB in IDLE, multiply accumulate or trial subtract in RUN
  always_comb begin
    is_iter = (ALUCtrl == OP_MUL) || (ALUCtrl[2:1] == 2'b11);
    is_sub  = (ALUCtrl == OP_SUB);
    add_a   = '0;
    add_b   = '0;
    cin     = 1'b0;
    if (state == RUN) begin
      if (op_q == OP_MUL) begin
        add_a = {1'b0, acc};
        add_b = qr[0] ? {1'b0, breg} : '0;
      end else begin
        add_a = {acc, qr[width-1]};
        add_b = ~{1'b0, breg};
        cin   = 1'b1;
      end
    end else begin
      add_a = {1'b0, A};
      add_b = {1'b0, (is_sub ? ~B : B)};
      cin   = is_sub;
    end
    sum = sum_w'(add_a) + sum_w'(add_b) + sum_w'(cin);
  end

  // Next iteration state and the value to write back on completion
  always_comb begin
    div_ge    = sum[width+1];
    acc_n     = '0;
    qr_n      = '0;
    fin_res   = '0;
    fin_v     = 1'b0;
    fin_c     = 1'b0;
    if (op_q == OP_MUL) begin
      acc_n = sum[width:1];
      qr_n  = {sum[0], qr[width-1:1]};
    end else begin
      acc_n = div_ge ? sum[width-1:0] : add_a[width-1:0];
      qr_n  = {qr[width-2:0], div_ge};
    end
    if (state == RUN) begin
      case (op_q)
        OP_MUL: begin
          fin_res = qr_n;
          fin_v   = |acc_n;
          fin_c   = |acc_n;
        end
        OP_DIVU: begin
          fin_res = qr_n;
          fin_v   = (breg == '0);
        end
        default: begin
          fin_res = acc_n;
          fin_v   = (breg == '0);
        end
      endcase
    end else begin
      case (ALUCtrl)
        OP_ADD, OP_SUB: begin
          fin_res = sum[width-1:0];
          fin_c   = sum[width];
          fin_v   = (A[width-1] == add_b[width-1]) && (sum[width-1] != A[width-1]);
        end
        OP_AND:  fin_res = A & B;
        OP_OR:   fin_res = A | B;
        OP_XOR:  fin_res = A ^ B;
        default: fin_res = '0;
      endcase
    end
    fin_flags = {fin_v, fin_c, fin_res[width-1], (fin_res == '0)};
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      acc      <= '0;
      qr       <= '0;
      breg     <= '0;
      Result   <= '0;
      ALUFlags <= 4'b0000;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_iter) begin
              op_q  <= ALUCtrl;
              breg  <= B;
              qr    <= A;
              acc   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              Result   <= fin_res;
              ALUFlags <= fin_flags;
              done     <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_n;
          qr  <= qr_n;
          cnt <= cnt + cnt_w'(1);
          if (cnt == last_cnt) begin
            Result   <= fin_res;
            ALUFlags <= fin_flags;
            done     <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
